fc_backprop_dx: RTL and testbench

//  Backward (error-propagation) pass of the fully-connected layer: dX[i] = sum_j W[i*Y_SIZE+j]*dY[j].

---
 rtl/fc_pkg.sv | 43 ++++
 rtl/fc_backprop_dx_if.sv | 33 +++
 rtl/fxp_mac_sat.sv | 42 ++++
 rtl/fc_backprop_dx.sv | 147 ++++++++++++++
 tb/tb_fc_backprop_dx.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Fixed-point helpers and the backward-pass state type shared by the fully-connected layer blocks.
package fc_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 12;
    localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        EMIT = 2'd2
    } bp_state_t;

    // Q3.12 x Q3.12 -> Q3.12.
    // The low fraction bits are dropped, so the result is floored toward -inf.
    // If the top bits of the product disagree, the value does not fit in Q3.12,
    // so it is clamped to the nearest extreme.
    function automatic logic [DATA_W-1:0] sat_mul_q312(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] p;
        logic [DATA_W-1:0]          q;
        p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        q = p[FRAC_W+DATA_W-1:FRAC_W];
        if (p[2*DATA_W-1:FRAC_W+DATA_W-1] != {(DATA_W-FRAC_W+1){p[2*DATA_W-1]}})
            q = p[2*DATA_W-1] ? Q_MIN : Q_MAX;
        return q;
    endfunction

    // Narrows a sign-extended accumulator value to a 16-bit word.
    // Out-of-range values clamp to the extremes.
    function automatic logic [DATA_W-1:0] sat16(input logic signed [31:0] v);
        logic [DATA_W-1:0] r;
        if (v > 32'sd32767)
            r = Q_MAX;
        else if (v < -32'sd32768)
            r = Q_MIN;
        else
            r = v[DATA_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/fc_backprop_dx_if.sv
// Stream and weight-RAM bus of the backward dX block.
// The slave side is the block itself.
// The master side is its environment: the dY producer, the weight RAM and the dX consumer.
interface fc_backprop_dx_if
    import fc_pkg::*;
#(
    parameter int AW = 14
);

    logic              dy_valid;
    logic              dy_ready;
    logic [DATA_W-1:0] dy_data;

    logic              w_rd_en;
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_rdata;

    logic              dx_valid;
    logic              dx_ready;
    logic [DATA_W-1:0] dx_data;
    logic              dx_last;

    modport master (
        output dy_valid, dy_data, w_rdata, dx_ready,
        input  dy_ready, w_rd_en, w_addr, dx_valid, dx_data, dx_last
    );

    modport slave (
        input  dy_valid, dy_data, w_rdata, dx_ready,
        output dy_ready, w_rd_en, w_addr, dx_valid, dx_data, dx_last
    );

endinterface

// File: rtl/fxp_mac_sat.sv
// Two-stage multiply-accumulate for Q3.12 operands.
// Stage 1 registers the saturated product; stage 2 adds it into a wide accumulator.
// 'en' marks a valid a/b pair this cycle.
// 'clr' empties both the pipeline and the accumulator.
module fxp_mac_sat
    import fc_pkg::*;
#(
    parameter int ACC_W = 24
)(
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic [DATA_W-1:0] prod_q;
    logic              prod_vld;

    // Product stage: capture the saturated product and remember whether it is a real term.
    always_ff @(posedge clk) begin
        if (RST || clr) begin
            prod_q   <= '0;
            prod_vld <= 1'b0;
        end else begin
            prod_vld <= en;
            if (en)
                prod_q <= sat_mul_q312(a, b);
        end
    end

    // Accumulate stage: add the sign-extended product whenever the product stage held a term.
    always_ff @(posedge clk) begin
        if (RST || clr)
            acc <= '0;
        else if (prod_vld)
            acc <= acc + ACC_W'($signed(prod_q));
    end

endmodule

// File: rtl/fc_backprop_dx.sv
// Backward pass of the fully-connected layer: dX[i] = sum_j W[i*Y_SIZE+j] * dY[j].
// dY is buffered once per frame.
// Each dX word then streams one row of the forward-layout weight RAM through the MAC.
module fc_backprop_dx
    import fc_pkg::*;
#(
    parameter int X_SIZE = 120,
    parameter int Y_SIZE = 84,
    parameter int ACC_W  = 24,
    parameter int AW     = $clog2(X_SIZE*Y_SIZE)
)(
    input  logic            clk,
    input  logic            RST,
    fc_backprop_dx_if.slave bus,
    output logic            busy
);

    localparam int JW = $clog2(Y_SIZE+1);
    localparam int IW = $clog2(X_SIZE+1);
    localparam int CW = $clog2(Y_SIZE+3);

    localparam logic [JW-1:0] J_LAST   = JW'(Y_SIZE-1);
    localparam logic [IW-1:0] I_LAST   = IW'(X_SIZE-1);
    localparam logic [CW-1:0] C_ISSUE  = CW'(Y_SIZE);
    localparam logic [CW-1:0] C_LAST   = CW'(Y_SIZE+1);
    localparam logic [AW-1:0] ROW_STEP = AW'(Y_SIZE);

    bp_state_t state, state_nxt;

    logic [JW-1:0]     j;
    logic [IW-1:0]     i;
    logic [CW-1:0]     mac_cnt;
    logic [AW-1:0]     row_base;
    logic              rd_vld;
    logic [JW-1:0]     rd_j;
    logic [DATA_W-1:0] dy_buf [Y_SIZE];

    logic              dy_fire;
    logic              dx_fire;
    logic              issue;
    logic              mac_clr;
    logic signed [ACC_W-1:0] acc;
    logic signed [31:0]      acc_ext;

    assign dy_fire = (state == LOAD) && bus.dy_valid;
    assign dx_fire = (state == EMIT) && bus.dx_ready;

    // Reads go out only in the first Y_SIZE MAC cycles.
    // The last two cycles drain the product and accumulate stages.
    assign issue   = (state == MAC) && (mac_cnt < C_ISSUE);
    assign mac_clr = (state == MAC) && (mac_cnt == '0);
    assign acc_ext = 32'(acc);

    assign bus.dy_ready = (state == LOAD);
    assign bus.w_rd_en  = issue;
    assign bus.w_addr   = row_base + AW'(mac_cnt);
    assign bus.dx_valid = (state == EMIT);
    assign bus.dx_last  = (state == EMIT) && (i == I_LAST);
    assign bus.dx_data  = (state == EMIT) ? sat16(acc_ext) : '0;
    assign busy         = (state != LOAD);

    // State register; any unknown encoding falls back to LOAD through the next-state default.
    always_ff @(posedge clk) begin
        if (RST)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    // Next state: fill dY, run one row through the MAC, hand the word off, repeat per row.
    always_comb begin
        state_nxt = LOAD;
        case (state)
            LOAD: state_nxt = (dy_fire && (j == J_LAST)) ? MAC : LOAD;
            MAC:  state_nxt = (mac_cnt == C_LAST) ? EMIT : MAC;
            EMIT: begin
                if (dx_fire)
                    state_nxt = (i == I_LAST) ? LOAD : MAC;
                else
                    state_nxt = EMIT;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Frame counters.
    // j walks the dY buffer and i walks the rows.
    // row_base tracks i*Y_SIZE so addressing needs only an adder.
    // mac_cnt times the MAC phase and is zero outside it.
    always_ff @(posedge clk) begin
        if (RST) begin
            j        <= '0;
            i        <= '0;
            mac_cnt  <= '0;
            row_base <= '0;
        end else begin
            if (dy_fire)
                j <= (j == J_LAST) ? '0 : j + JW'(1);

            if ((state == MAC) && (mac_cnt != C_LAST))
                mac_cnt <= mac_cnt + CW'(1);
            else
                mac_cnt <= '0;

            if (dx_fire) begin
                if (i == I_LAST) begin
                    i        <= '0;
                    row_base <= '0;
                end else begin
                    i        <= i + IW'(1);
                    row_base <= row_base + ROW_STEP;
                end
            end
        end
    end

    // Read-return alignment.
    // This remembers which dY entry pairs with the weight arriving next cycle.
    always_ff @(posedge clk) begin
        if (RST) begin
            rd_vld <= 1'b0;
            rd_j   <= '0;
        end else begin
            rd_vld <= issue;
            rd_j   <= JW'(mac_cnt);
        end
    end

    // dY storage; it is reused for every row of the frame, so it needs no reset.
    always_ff @(posedge clk) begin
        if (dy_fire)
            dy_buf[j] <= bus.dy_data;
    end

    fxp_mac_sat #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (clk),
        .RST (RST),
        .clr (mac_clr),
        .en  (rd_vld),
        .a   (bus.w_rdata),
        .b   (dy_buf[rd_j]),
        .acc (acc)
    );

endmodule

// File: tb/tb_fc_backprop_dx.sv
// Directed bench for fc_backprop_dx.
// A small 4x3 instance is driven with hand-computed vectors.
// A default-size instance runs one random frame against a reference sum.
module tb_fc_backprop_dx;
    import fc_pkg::*;

    localparam int XS    = 4;
    localparam int YS    = 3;
    localparam int AWS   = $clog2(XS*YS);
    localparam int XB    = 120;
    localparam int YB    = 84;
    localparam int AWB   = $clog2(XB*YB);
    localparam int LIMIT = 400;

    logic clk = 1'b0;
    logic RST;
    logic busy_s;
    logic busy_b;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int emit_rd    = 0;

    logic [15:0]    wmem_s [XS*YS];
    logic [15:0]    wmem_b [XB*YB];
    logic [15:0]    dy_b   [YB];
    logic [AWS-1:0] addr_q   [$];
    int             addr_cyc [$];

    fc_backprop_dx_if #(.AW(AWS)) bus_s ();
    fc_backprop_dx_if #(.AW(AWB)) bus_b ();

    fc_backprop_dx #(
        .X_SIZE (XS),
        .Y_SIZE (YS),
        .ACC_W  (24),
        .AW     (AWS)
    ) dut_s (
        .clk  (clk),
        .RST  (RST),
        .bus  (bus_s),
        .busy (busy_s)
    );

    fc_backprop_dx dut_b (
        .clk  (clk),
        .RST  (RST),
        .bus  (bus_b),
        .busy (busy_b)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Weight RAMs with one cycle of read latency.
    always @(posedge clk) begin
        if (bus_s.w_rd_en) bus_s.w_rdata <= wmem_s[bus_s.w_addr];
        if (bus_b.w_rd_en) bus_b.w_rdata <= wmem_b[bus_b.w_addr];
    end

    // Address log for the small instance, plus a count of reads that overlap a presented dX word.
    always @(posedge clk) begin
        if (bus_s.w_rd_en) begin
            addr_q.push_back(bus_s.w_addr);
            addr_cyc.push_back(cyc);
        end
        if (bus_s.w_rd_en && bus_s.dx_valid) emit_rd <= emit_rd + 1;
    end

    function automatic int mulq(input logic [15:0] w, input logic [15:0] d);
        int p;
        int q;
        p = int'($signed(w)) * int'($signed(d));
        q = p >>> 12;
        if (q > 32767) q = 32767;
        else if (q < -32768) q = -32768;
        return q;
    endfunction

    function automatic logic [15:0] model_dx(input int row);
        int s;
        s = 0;
        for (int k = 0; k < YB; k++) s += mulq(wmem_b[row*YB+k], dy_b[k]);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sendBeat(input logic [15:0] d);
        @(negedge clk);
        checkOutput("dy_ready", {31'd0, bus_s.dy_ready}, 32'd1);
        bus_s.dy_valid = 1'b1;
        bus_s.dy_data  = d;
        @(posedge clk);
    endtask

    task automatic endBeats();
        @(negedge clk);
        bus_s.dy_valid = 1'b0;
        bus_s.dy_data  = 16'h0000;
    endtask

    task automatic applyStimulus(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        sendBeat(d0);
        sendBeat(d1);
        sendBeat(d2);
        endBeats();
    endtask

    task automatic waitDx(output int n);
        n = 0;
        while (!bus_s.dx_valid && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("dx_valid_timeout", {31'd0, bus_s.dx_valid}, 32'd1);
    endtask

    task automatic takeWord(input string tag, input logic [15:0] exp, input logic exp_last, output int lat);
        waitDx(lat);
        checkOutput({tag, "_data"}, {16'd0, bus_s.dx_data}, {16'd0, exp});
        checkOutput({tag, "_last"}, {31'd0, bus_s.dx_last}, {31'd0, exp_last});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic takeFrame(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] ex [4];
        int lat;
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        for (int k = 0; k < XS; k++) begin
            takeWord($sformatf("%s_w%0d", tag, k), ex[k], (k == XS-1), lat);
            checkOutput($sformatf("%s_lat%0d", tag, k), lat, YS+2);
        end
        checkOutput({tag, "_idle_busy"}, {31'd0, busy_s}, 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_dy_ready"}, {31'd0, bus_s.dy_ready}, 32'd1);
        checkOutput({tag, "_w_rd_en"},  {31'd0, bus_s.w_rd_en},  32'd0);
        checkOutput({tag, "_w_addr"},   {28'd0, bus_s.w_addr},   32'd0);
        checkOutput({tag, "_dx_valid"}, {31'd0, bus_s.dx_valid}, 32'd0);
        checkOutput({tag, "_dx_data"},  {16'd0, bus_s.dx_data},  32'd0);
        checkOutput({tag, "_dx_last"},  {31'd0, bus_s.dx_last},  32'd0);
        checkOutput({tag, "_busy"},     {31'd0, busy_s},         32'd0);
    endtask

    initial begin
        int lat;
        int t0;
        int n;

        bus_s.dy_valid = 1'b0;
        bus_s.dy_data  = 16'h0000;
        bus_s.dx_ready = 1'b1;
        bus_b.dy_valid = 1'b0;
        bus_b.dy_data  = 16'h0000;
        bus_b.dx_ready = 1'b1;
        RST = 1'b1;

        // Step 1: reset values, then no reads until the third dY beat (with a gap in dy_valid).
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetValues("rst");
        RST = 1'b0;
        for (int k = 0; k < XS*YS; k++) wmem_s[k] = 16'h1000;
        addr_q.delete();
        addr_cyc.delete();
        sendBeat(16'h1000);
        sendBeat(16'h2000);
        endBeats();
        repeat (4) begin
            @(negedge clk);
            checkOutput("pre_w_rd_en", {31'd0, bus_s.w_rd_en}, 32'd0);
            checkOutput("pre_busy",    {31'd0, busy_s},        32'd0);
        end
        sendBeat(16'h0800);
        endBeats();

        // Step 2: unit weights, 1.0 + 2.0 + 0.5 = 3.5 on every row; addresses 0..11 in bursts.
        takeFrame("t2", 16'h3800, 16'h3800, 16'h3800, 16'h3800);
        checkOutput("addr_count", addr_q.size(), XS*YS);
        for (int k = 0; k < XS*YS && k < addr_q.size(); k++) begin
            checkOutput($sformatf("addr%0d", k), {28'd0, addr_q[k]}, k);
            if (k % YS != 0)
                checkOutput($sformatf("addr_gap%0d", k), addr_cyc[k] - addr_cyc[k-1], 1);
        end

        // Step 3: product and output saturation, both directions.
        for (int k = 0; k < XS*YS; k++) wmem_s[k] = 16'h7FFF;
        applyStimulus(16'h7FFF, 16'h7FFF, 16'h7FFF);
        takeFrame("t3p", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        applyStimulus(16'h8000, 16'h0000, 16'h0000);
        takeFrame("t3n", 16'h8000, 16'h8000, 16'h8000, 16'h8000);

        // Step 4: truncation toward -inf on a single-LSB product.
        for (int k = 0; k < XS*YS; k++) wmem_s[k] = 16'hFFFF;
        applyStimulus(16'h1000, 16'h0000, 16'h0000);
        takeFrame("t4n", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        for (int k = 0; k < XS*YS; k++) wmem_s[k] = 16'h0001;
        applyStimulus(16'h1000, 16'h0000, 16'h0000);
        takeFrame("t4p", 16'h0001, 16'h0001, 16'h0001, 16'h0001);

        // Step 5: row weights 0.25*(i+1) give dX = 0.875*(i+1); hold word 1 for 10 cycles.
        for (int r = 0; r < XS; r++)
            for (int k = 0; k < YS; k++) wmem_s[r*YS+k] = 16'(16'h0400 * (r+1));
        applyStimulus(16'h1000, 16'h2000, 16'h0800);
        takeWord("t5_w0", 16'h0E00, 1'b0, lat);
        bus_s.dx_ready = 1'b0;
        waitDx(lat);
        checkOutput("t5_w1_data", {16'd0, bus_s.dx_data}, 32'h1C00);
        repeat (10) begin
            @(negedge clk);
            checkOutput("t5_hold_valid", {31'd0, bus_s.dx_valid}, 32'd1);
            checkOutput("t5_hold_data",  {16'd0, bus_s.dx_data},  32'h1C00);
            checkOutput("t5_hold_last",  {31'd0, bus_s.dx_last},  32'd0);
            checkOutput("t5_hold_rd",    {31'd0, bus_s.w_rd_en},  32'd0);
        end
        bus_s.dx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        takeWord("t5_w2", 16'h2A00, 1'b0, lat);
        checkOutput("t5_w2_lat", lat, YS+2);
        takeWord("t5_w3", 16'h3800, 1'b1, lat);

        // Step 6: reset during the MAC of row 2, then a fresh frame: 1/16 - 1 + 1/8 = -0.8125.
        applyStimulus(16'h1000, 16'h2000, 16'h0800);
        takeWord("t6_w0", 16'h0E00, 1'b0, lat);
        takeWord("t6_w1", 16'h1C00, 1'b0, lat);
        @(negedge clk);
        RST = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetValues("midrst");
        RST = 1'b0;
        for (int k = 0; k < XS*YS; k++) wmem_s[k] = 16'h1000;
        applyStimulus(16'h0100, 16'hF000, 16'h0200);
        takeFrame("t6f", 16'hF300, 16'hF300, 16'hF300, 16'hF300);
        checkOutput("emit_reads", emit_rd, 0);

        // Default-size instance: one random frame against the reference sum, with frame timing.
        for (int k = 0; k < XB*YB; k++) wmem_b[k] = 16'($urandom);
        for (int k = 0; k < YB; k++) dy_b[k] = 16'($urandom);
        for (int k = 0; k < YB; k++) begin
            @(negedge clk);
            bus_b.dy_valid = 1'b1;
            bus_b.dy_data  = dy_b[k];
            @(posedge clk);
        end
        @(negedge clk);
        bus_b.dy_valid = 1'b0;
        t0 = cyc;
        for (int r = 0; r < XB; r++) begin
            n = 0;
            while (!bus_b.dx_valid && n < LIMIT) begin
                @(negedge clk);
                n++;
            end
            checkOutput("big_timeout", {31'd0, bus_b.dx_valid}, 32'd1);
            checkOutput($sformatf("big_w%0d", r), {16'd0, bus_b.dx_data}, {16'd0, model_dx(r)});
            checkOutput($sformatf("big_last%0d", r), {31'd0, bus_b.dx_last}, (r == XB-1));
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("big_frame_cycles", cyc - t0, XB*(YB+3));
        checkOutput("big_idle_busy", {31'd0, busy_b}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
